// File: rtl/rr_resource_arbiter.sv
// Round-robin arbiter sharing one valid/ready resource between NUM_REQ clients.
// Each grant covers up to MAX_HOLD accepted beats. Consecutive grants are separated by one idle cycle.
module rr_resource_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_HOLD   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [$clog2(NUM_REQ)-1:0]    gnt_idx,
    output logic                          gnt_valid,
    output logic                          res_valid,
    output logic [DATA_WIDTH-1:0]         res_data,
    input  logic                          res_ready
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam bit HOLD_LIMITED = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = HOLD_LIMITED ? CNT_W'(MAX_HOLD - 1) : '1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               owner_req;
    logic               beat_acc;
    logic               release_now;

    // Modulo-NUM_REQ increment; never produces an index >= NUM_REQ.
    function automatic logic [IDX_W-1:0] idx_next(input logic [IDX_W-1:0] i);
        return (i == IDX_LAST) ? '0 : i + IDX_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] cnt_inc_sat(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + CNT_W'(1);
    endfunction

    // First set request bit scanning from p upward with wrap.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                  input logic [IDX_W-1:0]   p);
        logic [IDX_W-1:0] cand;
        logic [IDX_W-1:0] pick;
        logic             found;
        cand  = p;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && r[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
            cand = idx_next(cand);
        end
        return pick;
    endfunction

    assign owner_req   = req[idx_q];
    assign beat_acc    = res_valid & res_ready;
    assign release_now = !owner_req ||
                         (HOLD_LIMITED && beat_acc && (cnt_q == CNT_LAST));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = GRANT;
                    idx_d   = rr_pick(req, ptr_q);
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                    ptr_d   = idx_next(idx_q);
                end else if (beat_acc) begin
                    cnt_d = cnt_inc_sat(cnt_q);
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // All grant outputs decode from registered state only; res_* add the live request.
    always_comb begin
        gnt       = '0;
        gnt_valid = (state_q == GRANT);
        res_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_valid && (idx_q == IDX_W'(i))) begin
                gnt[i]   = 1'b1;
                res_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign gnt_idx   = idx_q;
    assign res_valid = gnt_valid & owner_req;

    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(gnt));
    a_gnt_valid:  assert property (@(posedge clk) disable iff (!rst) gnt_valid == |gnt);
    a_gnt_idx:    assert property (@(posedge clk) disable iff (!rst) !gnt_valid || gnt[gnt_idx]);
    a_cnt_bound:  assert property (@(posedge clk) disable iff (!rst) !HOLD_LIMITED || cnt_q <= CNT_LAST);

endmodule

// File: tb/tb_rr_resource_arbiter.sv
// Directed bench for rr_resource_arbiter: main instance with MAX_HOLD=2,
// second instance with MAX_HOLD=0 for the unlimited-hold case.
module tb_rr_resource_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req, req_u;
    logic [31:0] req_data;
    logic        res_ready, ready_u;

    logic [3:0]  gnt, gnt_u;
    logic [1:0]  gnt_idx, gnt_idx_u;
    logic        gnt_valid, gnt_valid_u;
    logic        res_valid, res_valid_u;
    logic [7:0]  res_data, res_data_u;

    int checks   = 0;
    int failures = 0;

    rr_resource_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_HOLD(2)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid),
        .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready)
    );

    rr_resource_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_HOLD(0)) dut_u (
        .clk(clk), .rst(rst), .req(req_u), .req_data(req_data),
        .gnt(gnt_u), .gnt_idx(gnt_idx_u), .gnt_valid(gnt_valid_u),
        .res_valid(res_valid_u), .res_data(res_data_u), .res_ready(ready_u)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b0;
        req   = 4'b0000;
        req_u = 4'b0000;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; req = 4'b1111; res_ready = 1'b1; req_u = 4'b0000; ready_u = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || gnt_idx !== 2'd0 ||
                res_valid !== 1'b0 || res_data !== 8'h00) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d gnt=%b gv=%b idx=%0d rv=%b rd=%h want all zero",
                         c, gnt, gnt_valid, gnt_idx, res_valid, res_data);
            end
        end
        rst = 1'b1;
        tick();
        checks++;
        if (gnt !== 4'b0001 || gnt_valid !== 1'b1 || gnt_idx !== 2'd0) begin
            failures++;
            $display("FAIL reset_release gnt=%b gv=%b idx=%0d want gnt=0001 gv=1 idx=0",
                     gnt, gnt_valid, gnt_idx);
        end
    endtask

    task automatic test_round_robin();
        int         o;
        logic [3:0] eg;
        logic [7:0] ed;
        do_reset();
        req = 4'b1111; res_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            o  = n % 4;
            eg = 4'b0001 << o;
            ed = 8'(8'hA0 + o);
            for (int b = 0; b < 2; b++) begin
                tick();
                checks++;
                if (gnt !== eg || gnt_idx !== 2'(o) || res_valid !== 1'b1 || res_data !== ed) begin
                    failures++;
                    $display("FAIL rr_grant n=%0d beat=%0d gnt=%b idx=%0d rv=%b rd=%h want gnt=%b idx=%0d rv=1 rd=%h",
                             n, b, gnt, gnt_idx, res_valid, res_data, eg, o, ed);
                end
            end
            tick();
            checks++;
            if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || res_valid !== 1'b0 || res_data !== 8'h00) begin
                failures++;
                $display("FAIL rr_dead n=%0d gnt=%b gv=%b rv=%b rd=%h want all zero",
                         n, gnt, gnt_valid, res_valid, res_data);
            end
        end
    endtask

    task automatic test_early_release();
        do_reset();
        req = 4'b0100; res_ready = 1'b1;
        tick();
        checks++;
        if (gnt !== 4'b0100 || gnt_idx !== 2'd2) begin
            failures++;
            $display("FAIL early_grant gnt=%b idx=%0d want gnt=0100 idx=2", gnt, gnt_idx);
        end
        tick();
        req = 4'b0000;
        #1;
        checks++;
        if (res_valid !== 1'b0 || gnt !== 4'b0100) begin
            failures++;
            $display("FAIL early_drop_comb rv=%b gnt=%b want rv=0 gnt=0100", res_valid, gnt);
        end
        tick();
        checks++;
        if (gnt !== 4'b0000 || gnt_idx !== 2'd0 || dut.ptr_q !== 2'd3) begin
            failures++;
            $display("FAIL early_release gnt=%b idx=%0d ptr=%0d want gnt=0000 idx=0 ptr=3",
                     gnt, gnt_idx, dut.ptr_q);
        end
        req = 4'b0011;
        tick();
        checks++;
        if (gnt !== 4'b0001 || res_data !== 8'hA0) begin
            failures++;
            $display("FAIL wrap_grant gnt=%b rd=%h want gnt=0001 rd=a0", gnt, res_data);
        end
        tick();
        tick();
        tick();
        checks++;
        if (gnt !== 4'b0010 || gnt_idx !== 2'd1) begin
            failures++;
            $display("FAIL wrap_next gnt=%b idx=%0d want gnt=0010 idx=1", gnt, gnt_idx);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        req = 4'b0010; res_ready = 1'b0;
        tick();
        checks++;
        if (gnt !== 4'b0010 || dut.cnt_q !== 2'd0) begin
            failures++;
            $display("FAIL bp_grant gnt=%b cnt=%0d want gnt=0010 cnt=0", gnt, dut.cnt_q);
        end
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if (gnt !== 4'b0010 || dut.cnt_q !== 2'd0 || res_valid !== 1'b1 || res_data !== 8'hA1) begin
                failures++;
                $display("FAIL bp_stall cyc=%0d gnt=%b cnt=%0d rv=%b rd=%h want gnt=0010 cnt=0 rv=1 rd=a1",
                         c, gnt, dut.cnt_q, res_valid, res_data);
            end
        end
        res_ready = 1'b1;
        tick();
        checks++;
        if (gnt !== 4'b0010 || dut.cnt_q !== 2'd1) begin
            failures++;
            $display("FAIL bp_first_beat gnt=%b cnt=%0d want gnt=0010 cnt=1", gnt, dut.cnt_q);
        end
        tick();
        checks++;
        if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || dut.cnt_q !== 2'd0) begin
            failures++;
            $display("FAIL bp_release gnt=%b gv=%b cnt=%0d want gnt=0000 gv=0 cnt=0",
                     gnt, gnt_valid, dut.cnt_q);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        req = 4'b0001; res_ready = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (gnt_valid !== 1'b0 || gnt !== 4'b0000) begin
            failures++;
            $display("FAIL b2b_dead gv=%b gnt=%b want gv=0 gnt=0000", gnt_valid, gnt);
        end
        tick();
        checks++;
        if (gnt !== 4'b0001 || gnt_valid !== 1'b1) begin
            failures++;
            $display("FAIL b2b_regrant gnt=%b gv=%b want gnt=0001 gv=1", gnt, gnt_valid);
        end
    endtask

    task automatic test_unlimited();
        int beats;
        do_reset();
        req_u = 4'b1000; ready_u = 1'b1;
        tick();
        checks++;
        if (gnt_u !== 4'b1000 || gnt_idx_u !== 2'd3 || res_data_u !== 8'hA3) begin
            failures++;
            $display("FAIL unl_grant gnt=%b idx=%0d rd=%h want gnt=1000 idx=3 rd=a3",
                     gnt_u, gnt_idx_u, res_data_u);
        end
        beats = 0;
        for (int c = 0; c < 100; c++) begin
            if (res_valid_u && ready_u) beats++;
            tick();
            checks++;
            if (gnt_u !== 4'b1000 || gnt_valid_u !== 1'b1) begin
                failures++;
                $display("FAIL unl_hold cyc=%0d gnt=%b gv=%b want gnt=1000 gv=1", c, gnt_u, gnt_valid_u);
            end
        end
        checks++;
        if (beats !== 100) begin
            failures++;
            $display("FAIL unl_beats got=%0d want=100", beats);
        end
        req_u = 4'b0000;
        tick();
        checks++;
        if (gnt_u !== 4'b0000 || gnt_valid_u !== 1'b0 || res_valid_u !== 1'b0) begin
            failures++;
            $display("FAIL unl_drop gnt=%b gv=%b rv=%b want all zero", gnt_u, gnt_valid_u, res_valid_u);
        end
        ready_u = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        req = 4'b0001; res_ready = 1'b1;
        tick();
        tick();
        tick();
        req = 4'b0100;
        tick();
        tick();
        checks++;
        if (gnt !== 4'b0100 || gnt_idx !== 2'd2) begin
            failures++;
            $display("FAIL mid_owner gnt=%b idx=%0d want gnt=0100 idx=2", gnt, gnt_idx);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (gnt !== 4'b0000 || gnt_idx !== 2'd0 || gnt_valid !== 1'b0 ||
            res_valid !== 1'b0 || res_data !== 8'h00) begin
            failures++;
            $display("FAIL mid_reset gnt=%b idx=%0d gv=%b rv=%b rd=%h want all zero",
                     gnt, gnt_idx, gnt_valid, res_valid, res_data);
        end
        rst = 1'b1;
        req = 4'b1111;
        tick();
        checks++;
        if (gnt !== 4'b0001 || gnt_idx !== 2'd0) begin
            failures++;
            $display("FAIL mid_regrant gnt=%b idx=%0d want gnt=0001 idx=0", gnt, gnt_idx);
        end
        tick();
        checks++;
        if (gnt !== 4'b0001) begin
            failures++;
            $display("FAIL mid_cnt_cleared gnt=%b want 0001", gnt);
        end
    endtask

    initial begin
        req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        test_reset();
        test_round_robin();
        test_early_release();
        test_backpressure();
        test_back_to_back();
        test_unlimited();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_resource_arbiter.md
Name: rr_resource_arbiter

Overview:
- Round-robin arbiter sharing one downstream datapath resource between NUM_REQ requesters.
- A requester holds its grant for a burst of accepted beats, up to MAX_HOLD.
- It then yields, and the pointer advances to the next requester.
- Sits between requesting client modules and a single valid/ready resource port, e.g. a shared DATA_WIDTH-wide sink.

Parameters:
- NUM_REQ, 4: number of requesters; must be >= 2.
- DATA_WIDTH, 8: width of each requester data word and of res_data.
- MAX_HOLD, 4: maximum accepted beats per grant; 0 = unlimited (release only on req drop).

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- req  input  NUM_REQ  per-requester request, level; bit i = requester i.
- req_data  input  NUM_REQ*DATA_WIDTH  packed data; slice [i*DATA_WIDTH +: DATA_WIDTH] = requester i.
- gnt  output  NUM_REQ  registered one-hot grant; all-zero when no owner.
- gnt_idx  output  $clog2(NUM_REQ)  registered index of current owner; 0 when no owner.
- gnt_valid  output  1  registered; 1 while an owner exists (equals |gnt).
- res_valid  output  1  gnt_valid & req[gnt_idx].
- res_data  output  DATA_WIDTH  req_data slice selected by gnt_idx; 0 when gnt_valid=0.
- res_ready  input  1  resource accepts a beat when res_valid & res_ready.

Behaviour:
- Reset (rst=0 at a clock edge):
  - State goes to IDLE; gnt=0, gnt_idx=0, gnt_valid=0.
  - Round-robin pointer ptr=0; beat counter cnt=0.
  - res_valid=0 and res_data=0 from the cycle after the edge.
  - Reset overrides everything, including mid-burst; the in-flight beat is dropped and no handshake is implied.
- FSM states:
  - IDLE: no owner.
  - GRANT: owner = gnt_idx.
- IDLE:
  - If req != 0 at an edge, the winner is the first set bit scanning ptr, ptr+1, ..., wrapping at NUM_REQ-1 -> 0.
  - At that edge: gnt/gnt_idx load the winner, gnt_valid=1, cnt=0, go to GRANT.
  - Latency: req seen at edge t -> gnt high after edge t (one cycle).
  - If req = 0, stay in IDLE.
- GRANT:
  - Beat accepted at an edge where res_valid & res_ready; cnt increments on each accepted beat only.
  - Release at an edge when either condition holds:
    - (a) req[gnt_idx] = 0, or
    - (b) MAX_HOLD != 0 and a beat is accepted with cnt == MAX_HOLD-1.
  - On release: gnt=0, gnt_valid=0, gnt_idx=0, cnt=0, ptr = (owner+1) mod NUM_REQ, go to IDLE.
- Turnaround: exactly one cycle of gnt_valid=0 between consecutive grants, even if the same requester wins again.
- Backpressure: while res_ready=0 the grant is held indefinitely; cnt, gnt and res_data are unchanged (assuming stable req_data).
- Non-owner req changes during GRANT are ignored until the next IDLE arbitration.
- Owner drops req: res_valid goes low the same cycle (combinational); release happens at the next edge; no beat is counted.
- Req drop and accept cannot coincide, because res_valid includes req.
- cnt width: max(1, $clog2(MAX_HOLD+1)); never exceeds MAX_HOLD-1 when MAX_HOLD != 0.
- MAX_HOLD = 0: cnt saturates at its maximum and never triggers release.
- ptr wraps modulo NUM_REQ; for non-power-of-2 NUM_REQ, indices >= NUM_REQ are never produced.
- gnt is always one-hot or zero. Assertions:
  - $onehot0(gnt).
  - gnt_valid == |gnt.
  - gnt[gnt_idx] when gnt_valid.

Test Plan:
- Reset hold: rst=0, req=4'b1111, res_ready=1 for 5 cycles -> gnt=0, gnt_valid=0, res_valid=0, res_data=0. Release rst -> gnt=4'b0001 one edge later.
- Round robin: NUM_REQ=4, MAX_HOLD=2, req=4'b1111, res_ready=1 -> grants 0,1,2,3,0. Each grant lasts 2 accepted beats, with exactly 1 dead cycle between grants; res_data tracks the owner's slice.
- Early release and wrap: req=4'b0100 drops after 1 beat -> gnt=0 next cycle, ptr=3. Then req=4'b0011 -> gnt=4'b0001 (wrap past 3).
- Backpressure: owner 1, res_ready=0 for 6 cycles, then 1 -> gnt stays 4'b0010 and cnt stays 0 during the stall. Release after MAX_HOLD=2 accepted beats.
- Unlimited hold: MAX_HOLD=0, req=4'b1000 held, res_ready=1 for 100 cycles -> 100 beats, no release. Drop req -> gnt=0 next cycle.
- Reset mid-burst: owner 2 after 1 beat, pulse rst=0 for one edge -> gnt=0, gnt_idx=0. Then req=4'b1111 -> grant to 0 (ptr reset), not 3.
